// File: rtl/mac_tx_fcs_insert.sv
// TX MAC stage: zero-pads short frames, appends CRC-32 FCS LSB first, then holds off
// input for an inter-frame gap. Single output register stage, one cycle of latency.
//   state | meaning
//   IDLE  | waiting for the first byte of a frame
//   DATA  | forwarding frame bytes
//   PAD   | emitting 0x00 until the minimum length is reached
//   FCS   | emitting the four FCS bytes
//   IFG   | idle gap after the last FCS byte is accepted
module mac_tx_fcs_insert #(
   parameter int MIN_FRAME_LEN = 64,
   parameter int ENABLE_PAD    = 1,
   parameter int IFG_CYCLES    = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   output logic       s_tready,
   input  logic       s_tlast,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic       m_tlast,
   output logic       busy
);

   typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_PAD, ST_FCS, ST_IFG} state_t;

   localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LEN - 4);
   localparam logic [15:0] IFG_INIT   = 16'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);

   state_t      state_q, state_d;
   logic [7:0]  m_tdata_q, m_tdata_d;
   logic        m_tvalid_q, m_tvalid_d;
   logic        m_tlast_q, m_tlast_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] crc_q, crc_d;
   logic [2:0]  fcs_idx_q, fcs_idx_d;
   logic [15:0] ifg_q, ifg_d;

   logic        out_free;
   logic        in_acc;
   logic [15:0] cnt_inc;
   logic [15:0] cnt_new;
   logic [7:0]  load_byte;
   logic [31:0] crc_upd;
   logic [31:0] fcs;
   logic [7:0]  fcs_byte;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   assign out_free  = !m_tvalid_q || m_tready;
   assign s_tready  = out_free && ((state_q == ST_IDLE) || (state_q == ST_DATA));
   assign in_acc    = s_tvalid && s_tready;
   assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
   assign load_byte = (state_q == ST_PAD) ? 8'h00 : s_tdata;
   assign crc_upd   = crc32_byte(crc_q, load_byte);
   assign fcs       = ~crc_q;

   always_comb begin
      fcs_byte = fcs[7:0];
      case (fcs_idx_q[1:0])
         2'd0: fcs_byte = fcs[7:0];
         2'd1: fcs_byte = fcs[15:8];
         2'd2: fcs_byte = fcs[23:16];
         2'd3: fcs_byte = fcs[31:24];
         default: fcs_byte = fcs[7:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      cnt_d      = cnt_q;
      crc_d      = crc_q;
      fcs_idx_d  = fcs_idx_q;
      ifg_d      = ifg_q;
      cnt_new    = cnt_inc;
      case (state_q)
         ST_IDLE, ST_DATA: begin
            if (in_acc) begin
               cnt_new    = (state_q == ST_IDLE) ? 16'd1 : cnt_inc;
               m_tdata_d  = s_tdata;
               m_tvalid_d = 1'b1;
               m_tlast_d  = 1'b0;
               crc_d      = crc_upd;
               cnt_d      = cnt_new;
               fcs_idx_d  = 3'd0;
               if (!s_tlast) begin
                  state_d = ST_DATA;
               end else if ((ENABLE_PAD != 0) && (cnt_new < PAD_TARGET)) begin
                  state_d = ST_PAD;
               end else begin
                  state_d = ST_FCS;
               end
            end else if (out_free) begin
               m_tvalid_d = 1'b0;
            end
         end
         ST_PAD: begin
            if (out_free) begin
               m_tdata_d  = 8'h00;
               m_tvalid_d = 1'b1;
               m_tlast_d  = 1'b0;
               crc_d      = crc_upd;
               cnt_d      = cnt_inc;
               if (cnt_inc >= PAD_TARGET) state_d = ST_FCS;
            end
         end
         ST_FCS: begin
            // m_tlast_q is only ever set by the fourth FCS byte, so this is the frame's final handshake
            if (m_tvalid_q && m_tready && m_tlast_q) begin
               m_tvalid_d = 1'b0;
               m_tlast_d  = 1'b0;
               cnt_d      = 16'd0;
               if (IFG_CYCLES == 0) begin
                  state_d = ST_IDLE;
                  crc_d   = 32'hFFFF_FFFF;
               end else begin
                  state_d = ST_IFG;
                  ifg_d   = IFG_INIT;
               end
            end else if (out_free && (fcs_idx_q != 3'd4)) begin
               m_tdata_d  = fcs_byte;
               m_tvalid_d = 1'b1;
               m_tlast_d  = (fcs_idx_q == 3'd3);
               fcs_idx_d  = fcs_idx_q + 3'd1;
            end
         end
         ST_IFG: begin
            m_tvalid_d = 1'b0;
            if (ifg_q == 16'd0) begin
               state_d = ST_IDLE;
               crc_d   = 32'hFFFF_FFFF;
               cnt_d   = 16'd0;
            end else begin
               ifg_d = ifg_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         m_tdata_q  <= 8'h00;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         cnt_q      <= 16'd0;
         crc_q      <= 32'hFFFF_FFFF;
         fcs_idx_q  <= 3'd0;
         ifg_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         fcs_idx_q  <= fcs_idx_d;
         ifg_q      <= ifg_d;
      end
   end

   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign busy     = (state_q != ST_IDLE);

endmodule
